// File: rtl/ll_pkg.sv
// Shared definitions for the LocalLink copy engine.
// Holds the header/footer word indices, flag and status bit positions,
// the TX and RX FSM state types, and the status-word builder used for
// footer word 4.
package ll_pkg;

    // Header/footer word indices that carry fields
    localparam int HDR_FLAG_IDX = 4;
    localparam int HDR_LEN_IDX  = 5;

    // Op flag bit positions inside header/footer word 4
    localparam int FLAG_COMP    = 31;
    localparam int FLAG_DECOMP  = 30;
    localparam int FLAG_COPY    = 29;

    // Status bit positions inside footer word 4
    localparam int ST_LEN_ERR   = 28;
    localparam int ST_UNSUP     = 27;

    // The only op this engine actually performs
    localparam logic [2:0] OP_COPY = 3'b001;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_HDR,
        TX_PAYLOAD,
        TX_DRAIN,
        TX_WAIT
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_FOOTER
    } rx_state_t;

    // Footer word 4: op flags echoed back plus the two status bits
    function automatic logic [31:0] status_word(input logic [2:0] flags,
                                                input logic       len_err,
                                                input logic       unsup);
        logic [31:0] w;
        w = '0;
        w[FLAG_COMP]  = flags[2];
        w[FLAG_DECOMP] = flags[1];
        w[FLAG_COPY]  = flags[0];
        w[ST_LEN_ERR] = len_err;
        w[ST_UNSUP]   = unsup;
        return w;
    endfunction

endpackage

// File: rtl/ll_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// The head entry is always visible on rd_data while the FIFO is non-empty;
// rd_en pops it. Writes while full and reads while empty are ignored.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset (flushes the FIFO)
//   wr_en, wr_data  push side
//   rd_en, rd_data  pop side (rd_data is the current head)
//   count           number of stored entries, 0..DEPTH
//   empty, full     count == 0 / count == DEPTH
module ll_sync_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    // Storage has no reset; only the pointers and count define validity
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/ll_copy_engine.sv
// LocalLink DMA copy engine.
// Accepts a descriptor frame on TX (8-word header, then payload), buffers
// the payload of copy ops in a FWFT FIFO and replays it on RX, then emits
// an 8-word footer with the op flags, status bits and measured byte count.
// Non-copy ops have their payload drained and only the footer is returned.
// Ports:
//   clk, rst_n                         clock, synchronous active-low reset
//   tx_d, tx_rem, tx_*_n, tx_src_rdy_n TX LocalLink sink (header + payload in)
//   tx_dst_rdy_n                       TX ready from this block
//   rx_d, rx_rem, rx_*_n, rx_src_rdy_n RX LocalLink source (payload + footer out)
//   rx_dst_rdy_n                       RX ready from the downstream consumer
//   busy                               frame in progress (SOF seen, footer EOF not yet taken)
module ll_copy_engine #(
    parameter int DW         = 32,
    parameter int REMW       = $clog2(DW/8),
    parameter int FIFO_DEPTH = 256,
    parameter int START_LVL  = FIFO_DEPTH/2,
    parameter int HDR_WORDS  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DW-1:0]   tx_d,
    input  logic [REMW-1:0] tx_rem,
    input  logic            tx_sof_n,
    input  logic            tx_eof_n,
    input  logic            tx_sop_n,
    input  logic            tx_eop_n,
    input  logic            tx_src_rdy_n,
    output logic            tx_dst_rdy_n,
    output logic [DW-1:0]   rx_d,
    output logic [REMW-1:0] rx_rem,
    output logic            rx_sof_n,
    output logic            rx_eof_n,
    output logic            rx_sop_n,
    output logic            rx_eop_n,
    output logic            rx_src_rdy_n,
    input  logic            rx_dst_rdy_n,
    output logic            busy
);

    import ll_pkg::*;

    localparam int          FW  = DW + REMW + 2;
    localparam int          CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int          HCW = $clog2(HDR_WORDS);
    localparam logic [31:0] BYTES_PER_WORD = 32'(DW/8);

    tx_state_t       tx_state, tx_next;
    rx_state_t       rx_state, rx_next;

    logic            ready_q;
    logic [HCW-1:0]  hdr_cnt;
    logic [HCW-1:0]  ftr_cnt;
    logic [2:0]      flags;
    logic [31:0]     src_len;
    logic [31:0]     byte_cnt;
    logic            first_beat;
    logic            sop_err;
    logic            sof_pending;

    logic            tx_beat;
    logic            rx_beat;
    logic            footer_done;
    logic            len_err;
    logic            unsup;
    logic [31:0]     ftr_word;

    logic            fifo_wr;
    logic            fifo_rd;
    logic [FW-1:0]   fifo_din;
    logic [FW-1:0]   fifo_dout;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            fifo_full;

    logic            head_sop_n;
    logic            head_eop_n;
    logic [REMW-1:0] head_rem;
    logic [DW-1:0]   head_d;

    // Frame-end signalling rides on EOP; EOF carries no extra meaning here
    logic            unused_inputs;
    assign unused_inputs = tx_eof_n;

    ll_sync_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr),
        .wr_data (fifo_din),
        .rd_en   (fifo_rd),
        .rd_data (fifo_dout),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    assign fifo_din   = {tx_sop_n, tx_eop_n, tx_rem, tx_d};
    assign head_sop_n = fifo_dout[FW-1];
    assign head_eop_n = fifo_dout[FW-2];
    assign head_rem   = fifo_dout[DW +: REMW];
    assign head_d     = fifo_dout[DW-1:0];

    assign tx_beat     = !tx_src_rdy_n && !tx_dst_rdy_n;
    assign rx_beat     = !rx_src_rdy_n && !rx_dst_rdy_n;
    assign footer_done = (rx_state == RX_FOOTER) && rx_beat &&
                         (ftr_cnt == HCW'(HDR_WORDS-1));
    assign fifo_wr     = (tx_state == TX_PAYLOAD) && tx_beat;
    assign fifo_rd     = (rx_state == RX_DATA) && rx_beat;

    assign len_err = (byte_cnt != src_len) || sop_err;
    assign unsup   = (flags != OP_COPY);
    assign busy    = (tx_state != TX_IDLE);

    // State registers; ready_q keeps TX ready deasserted while in reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            rx_state <= RX_IDLE;
            ready_q  <= 1'b0;
        end else begin
            tx_state <= tx_next;
            rx_state <= rx_next;
            ready_q  <= 1'b1;
        end
    end

    // TX ready: payload is throttled only by a full FIFO, WAIT holds off the next frame
    always_comb begin
        tx_dst_rdy_n = 1'b1;
        if (ready_q) begin
            case (tx_state)
                TX_IDLE, TX_HDR, TX_DRAIN: tx_dst_rdy_n = 1'b0;
                TX_PAYLOAD:                tx_dst_rdy_n = fifo_full;
                default:                   tx_dst_rdy_n = 1'b1;
            endcase
        end
    end

    // TX next state: header, then payload or drain, then wait for the footer to go out
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE: begin
                if (tx_beat && !tx_sof_n) begin
                    tx_next = TX_HDR;
                end
            end
            TX_HDR: begin
                if (tx_beat && hdr_cnt == HCW'(HDR_WORDS-1)) begin
                    tx_next = (flags == OP_COPY) ? TX_PAYLOAD : TX_DRAIN;
                end
            end
            TX_PAYLOAD, TX_DRAIN: begin
                if (tx_beat && !tx_eop_n) begin
                    tx_next = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (footer_done) begin
                    tx_next = TX_IDLE;
                end
            end
            default: tx_next = TX_IDLE;
        endcase
    end

    // TX datapath: header field capture, byte counting and SOP check
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hdr_cnt    <= '0;
            flags      <= '0;
            src_len    <= '0;
            byte_cnt   <= '0;
            first_beat <= 1'b0;
            sop_err    <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_beat && !tx_sof_n) begin
                        hdr_cnt    <= HCW'(1);
                        flags      <= '0;
                        src_len    <= '0;
                        byte_cnt   <= '0;
                        first_beat <= 1'b1;
                        sop_err    <= 1'b0;
                    end
                end
                TX_HDR: begin
                    if (tx_beat) begin
                        hdr_cnt <= hdr_cnt + 1'b1;
                        if (hdr_cnt == HCW'(HDR_FLAG_IDX)) begin
                            flags <= {tx_d[FLAG_COMP], tx_d[FLAG_DECOMP], tx_d[FLAG_COPY]};
                        end
                        if (hdr_cnt == HCW'(HDR_LEN_IDX)) begin
                            src_len <= tx_d[31:0];
                        end
                    end
                end
                TX_PAYLOAD, TX_DRAIN: begin
                    if (tx_beat) begin
                        first_beat <= 1'b0;
                        if (first_beat && tx_sop_n) begin
                            sop_err <= 1'b1;
                        end
                        byte_cnt <= byte_cnt + (tx_eop_n ? BYTES_PER_WORD
                                                         : (32'(tx_rem) + 32'd1));
                    end
                end
                default: ;
            endcase
        end
    end

    // RX next state: start on threshold or once the whole payload is buffered;
    // a drained op goes straight to the footer
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE: begin
                if (tx_state == TX_WAIT && unsup) begin
                    rx_next = RX_FOOTER;
                end else if (fifo_count >= CW'(START_LVL) ||
                             (tx_state == TX_WAIT && !fifo_empty)) begin
                    rx_next = RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_beat && !head_eop_n) begin
                    rx_next = RX_FOOTER;
                end
            end
            RX_FOOTER: begin
                if (footer_done) begin
                    rx_next = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // RX bookkeeping: footer word counter and "SOF not yet sent" flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ftr_cnt     <= '0;
            sof_pending <= 1'b1;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    ftr_cnt     <= '0;
                    sof_pending <= 1'b1;
                end
                RX_DATA: begin
                    if (rx_beat) begin
                        sof_pending <= 1'b0;
                    end
                end
                RX_FOOTER: begin
                    if (rx_beat) begin
                        ftr_cnt     <= ftr_cnt + 1'b1;
                        sof_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Footer content: only the status word and the byte count are non-zero
    always_comb begin
        ftr_word = '0;
        if (ftr_cnt == HCW'(HDR_FLAG_IDX)) begin
            ftr_word = status_word(flags, len_err, unsup);
        end else if (ftr_cnt == HCW'(HDR_LEN_IDX)) begin
            ftr_word = byte_cnt;
        end
    end

    // RX outputs: FIFO head during DATA, footer mux during FOOTER, idle otherwise
    always_comb begin
        rx_src_rdy_n = 1'b1;
        rx_sof_n     = 1'b1;
        rx_eof_n     = 1'b1;
        rx_sop_n     = 1'b1;
        rx_eop_n     = 1'b1;
        rx_d         = '0;
        rx_rem       = '0;
        case (rx_state)
            RX_DATA: begin
                rx_src_rdy_n = fifo_empty;
                if (!fifo_empty) begin
                    rx_sof_n = !sof_pending;
                    rx_sop_n = head_sop_n;
                    rx_eop_n = head_eop_n;
                    rx_rem   = head_rem;
                    rx_d     = head_d;
                end
            end
            RX_FOOTER: begin
                rx_src_rdy_n = 1'b0;
                rx_sof_n     = !(sof_pending && ftr_cnt == '0);
                rx_eof_n     = !(ftr_cnt == HCW'(HDR_WORDS-1));
                rx_d         = DW'(ftr_word);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ll_copy_engine.sv
// Testbench for ll_copy_engine: one DW=32 and one DW=64 instance (FIFO_DEPTH=16)
// sharing stimulus; sel picks the active one. Expected RX beats are queued as
// frames are driven and compared by the RX monitor as they come out.
module tb_ll_copy_engine;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic [63:0] tx_d;
    logic [2:0]  tx_rem;
    logic        tx_sof_n, tx_eof_n, tx_sop_n, tx_eop_n;
    logic        tx_src_rdy_n;
    logic        rx_dst_rdy_n;

    logic        tx_src_rdy_n_32, tx_src_rdy_n_64;
    logic        rx_dst_rdy_n_32, rx_dst_rdy_n_64;

    logic        tx_dst_rdy_n_32, tx_dst_rdy_n_64;
    logic [31:0] rx_d_32;
    logic [63:0] rx_d_64;
    logic [1:0]  rx_rem_32;
    logic [2:0]  rx_rem_64;
    logic        rx_sof_n_32, rx_eof_n_32, rx_sop_n_32, rx_eop_n_32, rx_src_rdy_n_32, busy_32;
    logic        rx_sof_n_64, rx_eof_n_64, rx_sop_n_64, rx_eop_n_64, rx_src_rdy_n_64, busy_64;

    logic        cur_tx_dst_rdy_n, cur_rx_src_rdy_n, cur_busy;
    logic        cur_sof_n, cur_eof_n, cur_sop_n, cur_eop_n;
    logic [63:0] cur_rx_d;
    logic [2:0]  cur_rx_rem;

    typedef struct {
        logic [63:0] d;
        logic [2:0]  rem;
        logic        sof_n;
        logic        eof_n;
        logic        sop_n;
        logic        eop_n;
        bit          ftr;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    failures = 0;
    int    tx_beats = 0;

    assign tx_src_rdy_n_32 = tx_src_rdy_n | sel;
    assign tx_src_rdy_n_64 = tx_src_rdy_n | ~sel;
    assign rx_dst_rdy_n_32 = rx_dst_rdy_n | sel;
    assign rx_dst_rdy_n_64 = rx_dst_rdy_n | ~sel;

    ll_copy_engine #(.DW(32), .FIFO_DEPTH(16)) u32 (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_d         (tx_d[31:0]),
        .tx_rem       (tx_rem[1:0]),
        .tx_sof_n     (tx_sof_n),
        .tx_eof_n     (tx_eof_n),
        .tx_sop_n     (tx_sop_n),
        .tx_eop_n     (tx_eop_n),
        .tx_src_rdy_n (tx_src_rdy_n_32),
        .tx_dst_rdy_n (tx_dst_rdy_n_32),
        .rx_d         (rx_d_32),
        .rx_rem       (rx_rem_32),
        .rx_sof_n     (rx_sof_n_32),
        .rx_eof_n     (rx_eof_n_32),
        .rx_sop_n     (rx_sop_n_32),
        .rx_eop_n     (rx_eop_n_32),
        .rx_src_rdy_n (rx_src_rdy_n_32),
        .rx_dst_rdy_n (rx_dst_rdy_n_32),
        .busy         (busy_32)
    );

    ll_copy_engine #(.DW(64), .FIFO_DEPTH(16)) u64 (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_d         (tx_d),
        .tx_rem       (tx_rem),
        .tx_sof_n     (tx_sof_n),
        .tx_eof_n     (tx_eof_n),
        .tx_sop_n     (tx_sop_n),
        .tx_eop_n     (tx_eop_n),
        .tx_src_rdy_n (tx_src_rdy_n_64),
        .tx_dst_rdy_n (tx_dst_rdy_n_64),
        .rx_d         (rx_d_64),
        .rx_rem       (rx_rem_64),
        .rx_sof_n     (rx_sof_n_64),
        .rx_eof_n     (rx_eof_n_64),
        .rx_sop_n     (rx_sop_n_64),
        .rx_eop_n     (rx_eop_n_64),
        .rx_src_rdy_n (rx_src_rdy_n_64),
        .rx_dst_rdy_n (rx_dst_rdy_n_64),
        .busy         (busy_64)
    );

    // Active-instance view of the outputs
    always_comb begin
        cur_tx_dst_rdy_n = sel ? tx_dst_rdy_n_64 : tx_dst_rdy_n_32;
        cur_rx_src_rdy_n = sel ? rx_src_rdy_n_64 : rx_src_rdy_n_32;
        cur_busy         = sel ? busy_64 : busy_32;
        cur_sof_n        = sel ? rx_sof_n_64 : rx_sof_n_32;
        cur_eof_n        = sel ? rx_eof_n_64 : rx_eof_n_32;
        cur_sop_n        = sel ? rx_sop_n_64 : rx_sop_n_32;
        cur_eop_n        = sel ? rx_eop_n_64 : rx_eop_n_32;
        cur_rx_d         = sel ? rx_d_64 : {32'h0, rx_d_32};
        cur_rx_rem       = sel ? rx_rem_64 : {1'b0, rx_rem_32};
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RX monitor: every accepted beat must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && !cur_rx_src_rdy_n && !rx_dst_rdy_n) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                failures++;
                $error("FAIL unexpected_rx_beat observed=%h expected=none", cur_rx_d);
            end
            if (exp_q.size() > 0) begin
                beat_t e;
                e = exp_q.pop_front();
                check_output(e.ftr ? "ftr_data" : "rx_data", cur_rx_d, e.d);
                check_output(e.ftr ? "ftr_sof_eof" : "rx_sof_eof",
                             64'({cur_sof_n, cur_eof_n}), 64'({e.sof_n, e.eof_n}));
                if (!e.ftr) begin
                    check_output("rx_sop_eop", 64'({cur_sop_n, cur_eop_n}), 64'({e.sop_n, e.eop_n}));
                    if (!e.eop_n) begin
                        check_output("rx_rem", 64'(cur_rx_rem), 64'(e.rem));
                    end
                end
            end
        end
    end

    // Drive one TX beat and hold it until accepted (bounded)
    task automatic send_beat(input logic [63:0] d, input logic [2:0] rem,
                             input logic sof_n, input logic eof_n,
                             input logic sop_n, input logic eop_n);
        int  waited;
        bit  acc;
        waited = 0;
        acc    = 1'b0;
        tx_d = d; tx_rem = rem;
        tx_sof_n = sof_n; tx_eof_n = eof_n; tx_sop_n = sop_n; tx_eop_n = eop_n;
        tx_src_rdy_n = 1'b0;
        while (!acc && waited < 500) begin
            @(negedge clk);
            acc = !cur_tx_dst_rdy_n;
            @(posedge clk);
            #1;
            waited++;
        end
        if (!acc) begin
            check_output("tx_accept_timeout", 64'(acc), 64'd1);
        end
        tx_beats++;
    endtask

    // Send a descriptor frame; stop_at>0 abandons it after that many payload words
    task automatic apply_stimulus(input logic [31:0] flags_w, input logic [31:0] len,
                                  input int nwords, input logic [2:0] last_rem,
                                  input bit no_sop, input int stop_at,
                                  input logic [31:0] exp_w4, input logic [31:0] exp_w5);
        bit copy;
        bit keep;
        copy = (flags_w[31:29] == 3'b001);
        keep = (stop_at == 0);
        tx_beats = 0;
        for (int i = 0; i < 8; i++) begin
            logic [63:0] hw;
            hw = {32'hDEAD_BEEF, 32'h0000_1000 + 32'(i)};
            if (i == 4) hw[31:0] = flags_w;
            if (i == 5) hw[31:0] = len;
            send_beat(hw, 3'd0, (i == 0) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b1);
        end
        for (int i = 0; i < nwords && (keep || i < stop_at); i++) begin
            logic [63:0] pd;
            logic [2:0]  r;
            logic        last;
            logic        sop_n;
            beat_t       e;
            last  = (i == nwords - 1);
            pd    = {$urandom(), $urandom()};
            if (!sel) pd[63:32] = '0;
            r     = last ? last_rem : 3'd0;
            sop_n = (i == 0 && !no_sop) ? 1'b0 : 1'b1;
            if (keep && copy) begin
                e.d = pd; e.rem = r; e.sof_n = (i != 0); e.eof_n = 1'b1;
                e.sop_n = sop_n; e.eop_n = !last; e.ftr = 1'b0;
                exp_q.push_back(e);
            end
            send_beat(pd, r, 1'b1, !last, sop_n, !last);
        end
        tx_src_rdy_n = 1'b1;
        if (keep) begin
            for (int w = 0; w < 8; w++) begin
                beat_t e;
                e.d     = (w == 4) ? {32'h0, exp_w4} : (w == 5) ? {32'h0, exp_w5} : 64'h0;
                e.rem   = '0;
                e.sof_n = !(w == 0 && !copy);
                e.eof_n = (w != 7);
                e.sop_n = 1'b1;
                e.eop_n = 1'b1;
                e.ftr   = 1'b1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Wait (bounded) until every expected beat has appeared and the engine is idle
    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || cur_busy) && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        assert (exp_q.size() == 0 && !cur_busy) else begin
            failures++;
            $error("FAIL %s_done observed pending=%0d busy=%b expected pending=0 busy=0",
                   tag, exp_q.size(), cur_busy);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_n32"}, 64'({tx_dst_rdy_n_32, rx_sof_n_32, rx_eof_n_32, rx_sop_n_32,
                                          rx_eop_n_32, rx_src_rdy_n_32}), 64'h3F);
        check_output({tag, "_n64"}, 64'({tx_dst_rdy_n_64, rx_sof_n_64, rx_eof_n_64, rx_sop_n_64,
                                          rx_eop_n_64, rx_src_rdy_n_64}), 64'h3F);
        check_output({tag, "_busy"}, 64'({busy_32, busy_64}), 64'h0);
        check_output({tag, "_rxd"}, {rx_d_32, 32'h0} | rx_d_64, 64'h0);
        check_output({tag, "_rem"}, 64'({rx_rem_32, rx_rem_64}), 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; sel = 1'b0;
        tx_d = '0; tx_rem = '0;
        tx_sof_n = 1'b1; tx_eof_n = 1'b1; tx_sop_n = 1'b1; tx_eop_n = 1'b1;
        tx_src_rdy_n = 1'b1; rx_dst_rdy_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] DW=32 copy");
        apply_stimulus(32'h2000_0000, 32'd16, 4, 3'd3, 1'b0, 0, 32'h2000_0000, 32'd16);
        wait_done("t1");
        $display("[TB] DW=32 partial last word");
        apply_stimulus(32'h2000_0000, 32'd13, 4, 3'd0, 1'b0, 0, 32'h2000_0000, 32'd13);
        wait_done("t2");
        $display("[TB] DW=32 length mismatch");
        apply_stimulus(32'h2000_0000, 32'd20, 4, 3'd3, 1'b0, 0, 32'h3000_0000, 32'd16);
        wait_done("t3");
        $display("[TB] DW=32 unsupported op");
        apply_stimulus(32'h8000_0000, 32'd12, 3, 3'd3, 1'b0, 0, 32'h8800_0000, 32'd12);
        wait_done("t4");
        $display("[TB] DW=32 missing SOP");
        apply_stimulus(32'h2000_0000, 32'd8, 2, 3'd3, 1'b1, 0, 32'h3000_0000, 32'd8);
        wait_done("t4b");

        $display("[TB] DW=32 backpressure");
        rx_dst_rdy_n = 1'b1;
        fork
            apply_stimulus(32'h2000_0000, 32'd128, 32, 3'd3, 1'b0, 0, 32'h2000_0000, 32'd128);
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                check_output("t5_stall_rdy", 64'(cur_tx_dst_rdy_n), 64'd1);
                check_output("t5_stall_beats", 64'(tx_beats), 64'd24);
                check_output("t5_stall_busy", 64'(cur_busy), 64'd1);
                @(posedge clk);
                #1;
                rx_dst_rdy_n = 1'b0;
            end
        join
        wait_done("t5");

        $display("[TB] DW=32 reset mid-payload");
        apply_stimulus(32'h2000_0000, 32'd32, 8, 3'd3, 1'b0, 5, 32'h0, 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset("t6_reset");
        check_output("t6_fifo_empty", 64'(u32.u_fifo.empty), 64'd1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        apply_stimulus(32'h2000_0000, 32'd16, 4, 3'd3, 1'b0, 0, 32'h2000_0000, 32'd16);
        wait_done("t6");

        sel = 1'b1;
        $display("[TB] DW=64 copy");
        apply_stimulus(32'h2000_0000, 32'd16, 2, 3'd7, 1'b0, 0, 32'h2000_0000, 32'd16);
        wait_done("t1_64");
        apply_stimulus(32'h2000_0000, 32'd19, 3, 3'd2, 1'b0, 0, 32'h2000_0000, 32'd19);
        wait_done("t2_64");

        $display("[TB] DW=64 backpressure");
        rx_dst_rdy_n = 1'b1;
        fork
            apply_stimulus(32'h2000_0000, 32'd256, 32, 3'd7, 1'b0, 0, 32'h2000_0000, 32'd256);
            begin
                repeat (40) @(posedge clk);
                @(negedge clk);
                check_output("t5_64_stall_rdy", 64'(cur_tx_dst_rdy_n), 64'd1);
                check_output("t5_64_stall_beats", 64'(tx_beats), 64'd24);
                @(posedge clk);
                #1;
                rx_dst_rdy_n = 1'b0;
            end
        join
        wait_done("t5_64");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
